mmio_console: RTL and testbench
===============================

# mmio_console

Memory-mapped simulation console and exit peripheral on the data bus. It sits beside the RAM, RTC and PLIC and is selected by the top-level address decode through `en_i`. It replaces ad-hoc character and integer printing with per-channel byte FIFOs that drain through ready/valid ports, sticky overflow flags, an exit-code register with a halt flag, a free-running cycle counter and a maskable TX-empty interrupt.

## Interface

**Parameters**
- `CHANNELS`, 2 — number of independent output channels, 1..8.
- `FIFO_DEPTH`, 16 — bytes per channel FIFO; power of two, at least 2.
- `ADDR_WIDTH`, 12 — offset bits decoded from the bus address; at least 12.

**Ports**
- `clk`  in  1  — core clock.
- `reset_n`  in  1  — asynchronous active-low reset.
- `en_i`  in  1  — bus select for this block in the current cycle.
- `we_i`  in  4  — byte write enables. Any nonzero value marks a write; zero marks a read.
- `addr_i`  in  ADDR_WIDTH  — byte offset. Bits [1:0] are ignored.
- `data_i`  in  32  — write data.
- `data_o`  out  32  — registered read data.
- `tx_valid_o`  out  CHANNELS  — channel FIFO is non-empty.
- `tx_data_o`  out  8*CHANNELS  — head byte of each channel; channel c occupies [8c+7:8c].
- `tx_ready_i`  in  CHANNELS  — consumer accepts the head byte this cycle.
- `halt_o`  out  1  — sticky; the EXIT register has been written.
- `exit_code_o`  out  32  — last value written to EXIT.
- `irq_o`  out  1  — level interrupt.

## Operation

**Register map**
- Global registers live at page 0, where `addr_i[11:8]` = 0:
  - 0x000 EXIT: a write latches `data_i` into `exit_code_o` and sets `halt_o`. A read returns `exit_code_o`.
  - 0x004 CYCLE: read-only 32-bit counter. It increments every cycle while out of reset and wraps at 2^32−1 to 0.
  - 0x008 IRQ_EN: read/write. Bits [CHANNELS-1:0] are the per-channel TX-empty enables; upper bits read 0.
- Channel c (0..CHANNELS-1) lives at page c+1:
  - +0x0 TXDATA: a write pushes `data_i[7:0]`. If the FIFO is full, the byte is dropped and OVF is set. Reads return 0.
  - +0x4 STATUS: reads as {16'b0, count[7:0], 5'b0, OVF, FULL, EMPTY}. Writing 1 to bit 2 clears OVF; all other written bits are ignored.
- Unmapped offsets and out-of-range channel pages: reads return 0 and writes are ignored.

**FIFO**
- Each channel is a circular buffer with a read pointer, a write pointer and a count of width clog2(FIFO_DEPTH)+1.
- A pop occurs when `tx_valid_o[c]` and `tx_ready_i[c]` are both high.
- FULL is evaluated before any pop in the same cycle, so a push into a full FIFO is dropped even when a pop happens that cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- `tx_data_o[c]` holds the head entry; its value is don't-care while the FIFO is empty.

**Other behaviour**
- If an OVF set and an OVF clear occur in the same cycle, the set wins.
- `halt_o` stays set until reset. Further EXIT writes overwrite `exit_code_o`. TXDATA writes and drains continue after halt so that output is flushed.
- `irq_o` = |(IRQ_EN & EMPTY vector).

## Timing

**Reset values**
- `data_o`=0, `halt_o`=0, `exit_code_o`=0, CYCLE=0, IRQ_EN=0.
- All FIFOs are empty with OVF=0, so `tx_valid_o`=0 and `irq_o`=0.

**Reads**
- `data_o` is valid exactly one cycle after a cycle with `en_i`=1 and `we_i`=0.
- In the cycle after any other cycle (idle or write), `data_o` is 0.
- CYCLE returns the counter value sampled in the request cycle.

**Writes**
- Writes take effect at the clock edge that ends the request cycle.
- A pushed byte is visible on `tx_valid_o` and `tx_data_o` in the next cycle.
- A STATUS read returns the state before any same-cycle push or pop.
- `halt_o` and `exit_code_o` update one cycle after the EXIT write.

**Reset and throughput**
- Asserting `reset_n` low mid-operation clears all state immediately, without waiting for a clock edge. Buffered bytes are lost.
- Throughput is one push and one pop per channel per cycle. Channels are fully independent.

## Test plan

- **Reset:** hold `reset_n`=0 for 3 cycles, then release → all outputs 0; CYCLE read 10 cycles later returns 9 or 10 consistently with the request cycle.
- **Echo:** write 0x41, 0x42, 0x43 to channel 0 TXDATA with `tx_ready_i`=0 → STATUS reads 0x00000300; raise ready → 'A','B','C' drain on consecutive cycles, then `tx_valid_o[0]`=0.
- **Overflow:** push 17 bytes into channel 1 with DEPTH 16 and no drain → STATUS=0x00001006 (count 16, OVF, FULL); write 0x4 to STATUS → 0x00001002. Repeat the 17th push with a simultaneous pop → byte dropped and OVF set again.
- **Wrap:** push and pop 40 bytes through channel 0 with random ready → byte order preserved across pointer wrap and count never exceeds 16.
- **Interrupt:** IRQ_EN=0x2 with channel 1 empty → `irq_o`=1; push a byte → `irq_o`=0 the next cycle; drain it → `irq_o`=1.
- **Exit:** write 0xDEAD0001 to EXIT while channel 0 holds 4 bytes → `halt_o`=1 and `exit_code_o`=0xDEAD0001 next cycle, the 4 bytes still drain, and pulsing `reset_n` low clears `halt_o` asynchronously.

Source files
------------

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped simulation console and exit peripheral.
// Per-channel byte FIFOs drain through ready/valid ports. The block also holds
// an exit-code register with a sticky halt flag, a free-running cycle counter
// and a maskable TX-empty interrupt.
module mmio_console #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en_i,
  input  logic [3:0]              we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [31:0]             data_i,
  output logic [31:0]             data_o,
  output logic [CHANNELS-1:0]     tx_valid_o,
  output logic [8*CHANNELS-1:0]   tx_data_o,
  input  logic [CHANNELS-1:0]     tx_ready_i,
  output logic                    halt_o,
  output logic [31:0]             exit_code_o,
  output logic                    irq_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Address decode: page selects global block or a channel, off selects the word.
  logic [3:0] page;
  logic [5:0] off;
  logic       hi_zero;
  logic       is_wr;
  logic       is_rd;
  logic       unused_addr;

  assign page        = addr_i[11:8];
  assign off         = addr_i[7:2];
  // Offsets beyond the 4 KiB window are treated as unmapped.
  assign hi_zero     = ((addr_i >> 12) == '0);
  assign is_wr       = en_i && (we_i != 4'b0000) && hi_zero;
  assign is_rd       = en_i && (we_i == 4'b0000) && hi_zero;
  assign unused_addr = ^addr_i[1:0];

  // Global registers.
  logic [31:0]         exit_q;
  logic                halt_q;
  logic [31:0]         cycle_q;
  logic [CHANNELS-1:0] irq_en_q;
  logic [31:0]         data_q;
  logic [31:0]         data_d;

  // Per-channel status gathered from the channel generate blocks.
  logic [CHANNELS-1:0] empty_w;
  logic [CHANNELS-1:0] full_w;
  logic [31:0]         status_w [CHANNELS];

  // Global register updates: exit code, halt flag, cycle counter, IRQ enables, read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exit_q   <= '0;
      halt_q   <= 1'b0;
      cycle_q  <= '0;
      irq_en_q <= '0;
      data_q   <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      data_q  <= data_d;
      if (is_wr && page == 4'd0 && off == 6'd0) begin
        exit_q <= data_i;
        halt_q <= 1'b1;
      end
      if (is_wr && page == 4'd0 && off == 6'd2) begin
        irq_en_q <= data_i[CHANNELS-1:0];
      end
    end
  end

  // Channel FIFOs: circular buffer with read/write pointers, count and sticky OVF.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          sel;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          ovf_clr;

    assign sel        = (page == 4'(c + 1));
    assign push       = is_wr && sel && (off == 6'd0);
    assign ovf_clr    = is_wr && sel && (off == 6'd1) && data_i[2];
    // FULL is judged on the pre-pop count, so a push into a full FIFO drops
    // even if the head is popped in the same cycle.
    assign full_w[c]  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty_w[c] = (cnt_q == '0);
    assign pop        = !empty_w[c] && tx_ready_i[c];
    assign push_ok    = push && !full_w[c];

    assign tx_valid_o[c]     = !empty_w[c];
    assign tx_data_o[8*c +: 8] = mem_q[rd_ptr_q];
    assign status_w[c] = {16'b0, 8'(cnt_q), 5'b0, ovf_q, full_w[c], empty_w[c]};

    // Pointer, count and overflow-flag control.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push_ok && !pop)      cnt_q <= cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_q <= cnt_q - CW'(1);
        // A same-cycle overflow beats a software clear.
        if (push && full_w[c]) ovf_q <= 1'b1;
        else if (ovf_clr)      ovf_q <= 1'b0;
      end
    end

    // Byte storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i[7:0];
    end
  end

  // Read mux: state as seen in the request cycle, zero for writes, idle and holes.
  always_comb begin
    data_d = '0;
    if (is_rd) begin
      if (page == 4'd0) begin
        case (off)
          6'd0:    data_d = exit_q;
          6'd1:    data_d = cycle_q;
          6'd2:    data_d[CHANNELS-1:0] = irq_en_q;
          default: data_d = '0;
        endcase
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (page == 4'(c + 1) && off == 6'd1) data_d = status_w[c];
        end
      end
    end
  end

  assign data_o      = data_q;
  assign halt_o      = halt_q;
  assign exit_code_o = exit_q;
  assign irq_o       = |(irq_en_q & empty_w);

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console (CHANNELS=2, FIFO_DEPTH=16).
module tb_mmio_console;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en_i;
  logic [3:0]  we_i;
  logic [11:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [1:0]  tx_valid_o;
  logic [15:0] tx_data_o;
  logic [1:0]  tx_ready_i;
  logic        halt_o;
  logic [31:0] exit_code_o;
  logic        irq_o;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_console #(.CHANNELS(2), .FIFO_DEPTH(16), .ADDR_WIDTH(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (en_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .halt_o      (halt_o),
    .exit_code_o (exit_code_o),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
    @(negedge clk);
    en_i = 1'b0; we_i = 4'h0; data_i = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    en_i = 1'b1; we_i = 4'h0; addr_i = a;
    @(negedge clk);
    en_i = 1'b0;
    d = data_o;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  q[$];
    logic [7:0]  head;
    int          sent;
    int          guard;
    logic        r;
    logic        p;

    reset_n = 1'b0; en_i = 1'b0; we_i = '0; addr_i = '0; data_i = '0; tx_ready_i = '0;

    // Reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_halt", 32'(halt_o), 32'h0);
    chk("rst_exit", exit_code_o, 32'h0);
    chk("rst_valid", 32'(tx_valid_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    repeat (10) @(negedge clk);
    rd(12'h004, v); chk("cycle_read", v, 32'd10);
    @(negedge clk); chk("data_o_idle_zero", data_o, 32'h0);
    rd(12'h008, v); chk("irq_en_reset", v, 32'h0);
    rd(12'h000, v); chk("exit_reset", v, 32'h0);

    // Echo
    wr(12'h100, 32'h41);
    chk("echo_valid", 32'(tx_valid_o[0]), 32'h1);
    chk("echo_head", 32'(tx_data_o[7:0]), 32'h41);
    wr(12'h100, 32'h42);
    wr(12'h100, 32'h43);
    rd(12'h104, v); chk("echo_status", v, 32'h00000300);
    tx_ready_i[0] = 1'b1;
    chk("echo_A", 32'(tx_data_o[7:0]), 32'h41);
    @(negedge clk); chk("echo_B", 32'(tx_data_o[7:0]), 32'h42);
    @(negedge clk); chk("echo_C", 32'(tx_data_o[7:0]), 32'h43);
    @(negedge clk); chk("echo_drained", 32'(tx_valid_o[0]), 32'h0);
    tx_ready_i[0] = 1'b0;

    // Unmapped holes and write-only register
    rd(12'h00C, v); chk("unmapped_global", v, 32'h0);
    rd(12'h304, v); chk("unmapped_page3", v, 32'h0);
    rd(12'h100, v); chk("txdata_reads_zero", v, 32'h0);

    // Overflow
    for (int i = 0; i < 17; i++) wr(12'h200, 32'(i));
    rd(12'h204, v); chk("ovf_status_full", v, 32'h00001006);
    wr(12'h204, 32'h4);
    rd(12'h204, v); chk("ovf_cleared", v, 32'h00001002);
    tx_ready_i[1] = 1'b1;
    wr(12'h200, 32'hEE);
    tx_ready_i[1] = 1'b0;
    rd(12'h204, v); chk("ovf_push_pop_full", v, 32'h00000F04);
    tx_ready_i[1] = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("ovf_drain_order", 32'(tx_data_o[15:8]), 32'(i));
      @(negedge clk);
    end
    tx_ready_i[1] = 1'b0;
    chk("ovf_drained", 32'(tx_valid_o[1]), 32'h0);
    rd(12'h204, v); chk("ovf_sticky_empty", v, 32'h00000005);
    wr(12'h204, 32'h4);

    // Wrap with random ready
    sent = 0; guard = 0;
    while ((sent < 40 || q.size() != 0) && guard < 1000) begin
      guard++;
      r = 1'($urandom_range(0, 1));
      p = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 3) != 0);
      tx_ready_i[0] = r;
      en_i = p; we_i = p ? 4'hF : 4'h0; addr_i = 12'h100; data_i = 32'h80 + 32'(sent);
      chk("wrap_valid", 32'(tx_valid_o[0]), 32'(q.size() != 0));
      if (r && q.size() != 0) begin
        head = q.pop_front();
        chk("wrap_byte", 32'(tx_data_o[7:0]), 32'(head));
      end
      if (p) begin
        q.push_back(8'(32'h80 + 32'(sent)));
        sent++;
      end
      @(negedge clk);
    end
    en_i = 1'b0; we_i = '0; tx_ready_i = '0;
    chk("wrap_timeout", 32'(guard < 1000), 32'h1);
    rd(12'h104, v); chk("wrap_final_status", v, 32'h00000001);

    // Interrupt
    wr(12'h008, 32'h2);
    chk("irq_empty", 32'(irq_o), 32'h1);
    rd(12'h008, v); chk("irq_en_read", v, 32'h2);
    wr(12'h200, 32'h55);
    chk("irq_nonempty", 32'(irq_o), 32'h0);
    tx_ready_i[1] = 1'b1;
    @(negedge clk);
    tx_ready_i[1] = 1'b0;
    chk("irq_drained", 32'(irq_o), 32'h1);
    wr(12'h008, 32'hFFFFFFFF);
    rd(12'h008, v); chk("irq_en_upper_zero", v, 32'h3);
    wr(12'h008, 32'h0);
    chk("irq_disabled", 32'(irq_o), 32'h0);

    // Exit
    for (int i = 0; i < 4; i++) wr(12'h100, 32'h10 + 32'(i));
    wr(12'h000, 32'hDEAD0001);
    chk("exit_halt", 32'(halt_o), 32'h1);
    chk("exit_code", exit_code_o, 32'hDEAD0001);
    chk("data_o_after_write", data_o, 32'h0);
    rd(12'h000, v); chk("exit_read", v, 32'hDEAD0001);
    tx_ready_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("exit_drain", 32'(tx_data_o[7:0]), 32'h10 + 32'(i));
      @(negedge clk);
    end
    tx_ready_i[0] = 1'b0;
    chk("exit_drained", 32'(tx_valid_o[0]), 32'h0);
    chk("halt_sticky", 32'(halt_o), 32'h1);
    wr(12'h100, 32'h77);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_halt", 32'(halt_o), 32'h0);
    chk("async_rst_exit", exit_code_o, 32'h0);
    chk("async_rst_valid", 32'(tx_valid_o), 32'h0);
    #1 reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
